// File: rtl/spi_shift_engine.sv
// SPI serialiser/deserialiser: variable frame length, per-frame bit order,
// separate sample/shift strobes, back-to-back loading and collision pulses.
module spi_shift_engine #(
   parameter int DATA_LEN = 8,
   parameter int CNT_W    = $clog2(DATA_LEN + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_LEN-1:0] data_in,
   input  logic                load,
   input  logic                lsb_first,
   input  logic [CNT_W-1:0]    frame_len,
   input  logic                sample_en,
   input  logic                shift_en,
   input  logic                serial_in,
   output logic                serial_out,
   output logic                busy,
   output logic                done,
   output logic [DATA_LEN-1:0] rx_data,
   output logic                collision
);

   localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_LEN);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t              state, state_nx;
   logic [DATA_LEN-1:0] sr;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    len;
   logic                lsb_mode;
   logic                latch;

   logic [CNT_W-1:0]    eff_len;
   logic [DATA_LEN-1:0] len_mask, len_top, load_mask, shifted;
   logic                shift_act, last_shift, load_ok, ins_bit;

   always_comb begin
      eff_len   = frame_len;
      len_mask  = '0;
      len_top   = '0;
      load_mask = '0;
      if (frame_len == '0 || frame_len > FULL_LEN)
         eff_len = FULL_LEN;
      // Masks in place of variable part-selects: bits below len, and the len-1 position
      for (int unsigned i = 0; i < DATA_LEN; i++) begin
         len_mask[i]  = CNT_W'(i) < len;
         len_top[i]   = CNT_W'(i) == len - CNT_W'(1);
         load_mask[i] = CNT_W'(i) < eff_len;
      end
   end

   always_comb begin
      busy       = (state == ST_BUSY);
      shift_act  = busy && shift_en;
      last_shift = shift_act && (cnt == CNT_W'(1));
      load_ok    = load && (!busy || last_shift);
      ins_bit    = sample_en ? serial_in : latch;
      if (lsb_mode)
         shifted = (sr >> 1) | (len_top & {DATA_LEN{ins_bit}});
      else
         shifted = ((sr << 1) | DATA_LEN'(ins_bit)) & len_mask;
      serial_out = busy && (lsb_mode ? sr[0] : |(sr & len_top));
   end

   always_comb begin
      state_nx = state;
      if (load_ok)
         state_nx = ST_BUSY;
      else if (last_shift)
         state_nx = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         cnt       <= '0;
         len       <= FULL_LEN;
         lsb_mode  <= 1'b0;
         latch     <= 1'b0;
         done      <= 1'b0;
         collision <= 1'b0;
         rx_data   <= '0;
      end else begin
         done      <= last_shift;
         collision <= load && !load_ok;
         if (busy && sample_en)
            latch <= serial_in;
         if (last_shift)
            rx_data <= shifted;
         if (load_ok) begin
            sr       <= data_in & load_mask;
            len      <= eff_len;
            cnt      <= eff_len;
            lsb_mode <= lsb_first;
         end else if (shift_act) begin
            sr  <= shifted;
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: vector table plus hand-written
// sequences for loopback, back-to-back loading and collision.
module tb_spi_shift_engine;

   localparam int DATA_LEN = 8;
   localparam int CNT_W    = $clog2(DATA_LEN + 1);

   logic                clk = 1'b0;
   logic                rst, load, lsb_first, sample_en, shift_en, sin, loop_mode;
   logic [DATA_LEN-1:0] data_in;
   logic [CNT_W-1:0]    frame_len;
   logic                serial_in, serial_out, busy, done, collision;
   logic [DATA_LEN-1:0] rx_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign serial_in = loop_mode ? serial_out : sin;

   spi_shift_engine #(.DATA_LEN(DATA_LEN)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .load(load), .lsb_first(lsb_first),
      .frame_len(frame_len), .sample_en(sample_en), .shift_en(shift_en),
      .serial_in(serial_in), .serial_out(serial_out), .busy(busy), .done(done),
      .rx_data(rx_data), .collision(collision)
   );

   typedef struct {
      logic       rst, load, lsb;
      logic [3:0] flen;
      logic [7:0] data;
      logic       smp, shf, sin;
      logic       sout, busy, done, coll;
      logic [7:0] rx;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, ld, lsb, input logic [3:0] fl, input logic [7:0] d,
                      input logic sm, sh, si, so, bz, dn, co, input logic [7:0] rx);
      vec_t v;
      v.rst = r; v.load = ld; v.lsb = lsb; v.flen = fl; v.data = d;
      v.smp = sm; v.shf = sh; v.sin = si;
      v.sout = so; v.busy = bz; v.done = dn; v.coll = co; v.rx = rx;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      rst = 0; load = 0; lsb_first = 0; frame_len = '0; data_in = '0;
      sample_en = 0; shift_en = 0; sin = 0;
   endtask

   initial begin
      logic [7:0] a5;
      idle_inputs();
      loop_mode = 0;
      a5 = 8'hA5;

      //  rst ld lsb fl  data   sm sh si   so bz dn co rx
      add(1, 0, 0, 0,  8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h00);
      // LSB first 0x3C, simultaneous strobes, serial_in 1,1,0,0,0,0,0,1
      add(0, 1, 1, 8,  8'h3C, 0, 0, 0,   0, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   0, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   1, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   1, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   1, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   1, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   0, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   0, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   0, 0, 1, 0, 8'h83);
      add(0, 0, 0, 0,  8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h83);
      // idle strobes change nothing
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   0, 0, 0, 0, 8'h83);
      add(0, 0, 0, 0,  8'h00, 1, 0, 0,   0, 0, 0, 0, 8'h83);
      // short frame, 5 bits MSB first, serial_in 1,0,1,1,0
      add(0, 1, 0, 5,  8'hFF, 0, 0, 0,   1, 1, 0, 0, 8'h83);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   1, 1, 0, 0, 8'h83);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   1, 1, 0, 0, 8'h83);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   1, 1, 0, 0, 8'h83);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   1, 1, 0, 0, 8'h83);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   0, 0, 1, 0, 8'h16);
      // reset after 3 shifts, then ignored strobes
      add(0, 1, 0, 0,  8'hA5, 0, 0, 0,   1, 1, 0, 0, 8'h16);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   0, 1, 0, 0, 8'h16);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   1, 1, 0, 0, 8'h16);
      add(0, 0, 0, 0,  8'h00, 1, 1, 0,   0, 1, 0, 0, 8'h16);
      add(1, 0, 0, 0,  8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   0, 0, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 0, 1, 1,   0, 0, 0, 0, 8'h00);
      // frame_len 12 behaves as 8
      add(0, 1, 0, 12, 8'h80, 0, 0, 0,   1, 1, 0, 0, 8'h00);
      for (int i = 0; i < 7; i++)
         add(0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'h00);
      add(0, 0, 0, 0,  8'h00, 1, 1, 1,   0, 0, 1, 0, 8'hFF);

      foreach (vecs[k]) begin
         rst = vecs[k].rst; load = vecs[k].load; lsb_first = vecs[k].lsb;
         frame_len = vecs[k].flen; data_in = vecs[k].data;
         sample_en = vecs[k].smp; shift_en = vecs[k].shf; sin = vecs[k].sin;
         step();
         check($sformatf("vec%0d.serial_out", k), 32'(serial_out), 32'(vecs[k].sout));
         check($sformatf("vec%0d.busy", k),       32'(busy),       32'(vecs[k].busy));
         check($sformatf("vec%0d.done", k),       32'(done),       32'(vecs[k].done));
         check($sformatf("vec%0d.collision", k),  32'(collision),  32'(vecs[k].coll));
         check($sformatf("vec%0d.rx_data", k),    32'(rx_data),    32'(vecs[k].rx));
      end
      idle_inputs();
      step();

      // Loopback MSB first: sample cycle, then shift from the latch
      loop_mode = 1;
      load = 1; data_in = 8'hA5; frame_len = '0;
      step();
      load = 0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("loop.bit%0d", i), 32'(serial_out), 32'(a5[7-i]));
         sample_en = 1; step(); sample_en = 0;
         shift_en = 1;  step(); shift_en = 0;
         check($sformatf("loop.done%0d", i), 32'(done), (i == 7) ? 32'd1 : 32'd0);
      end
      check("loop.rx_data", 32'(rx_data), 32'hA5);
      check("loop.busy", 32'(busy), 32'd0);
      step();
      check("loop.done_clear", 32'(done), 32'd0);
      loop_mode = 0;

      // Back-to-back: 3-bit frame 0x81, reload 0x42 on the final shift
      sin = 1; load = 1; data_in = 8'h81; frame_len = 4'd3;
      step();
      load = 0;
      check("b2b.first_bit", 32'(serial_out), 32'd0);
      sample_en = 1; shift_en = 1;
      step();
      check("b2b.s1.sout", 32'(serial_out), 32'd0);
      check("b2b.s1.busy", 32'(busy), 32'd1);
      step();
      check("b2b.s2.sout", 32'(serial_out), 32'd1);
      load = 1; data_in = 8'h42; frame_len = '0;
      step();
      check("b2b.done", 32'(done), 32'd1);
      check("b2b.busy", 32'(busy), 32'd1);
      check("b2b.rx_data", 32'(rx_data), 32'h07);
      check("b2b.no_collision", 32'(collision), 32'd0);
      check("b2b.new_first_bit", 32'(serial_out), 32'd0);
      // load during a non-final shift: shift proceeds, collision pulses
      data_in = 8'h55;
      step();
      check("coll.pulse", 32'(collision), 32'd1);
      check("coll.sout", 32'(serial_out), 32'd1);
      check("coll.no_done", 32'(done), 32'd0);
      load = 0; sample_en = 0; shift_en = 0;
      step();
      check("coll.clear", 32'(collision), 32'd0);
      check("coll.hold_sout", 32'(serial_out), 32'd1);
      load = 1;
      step();
      check("coll.idle_pulse", 32'(collision), 32'd1);
      check("coll.idle_sout", 32'(serial_out), 32'd1);
      load = 0; sin = 0; sample_en = 1; shift_en = 1;
      for (int i = 0; i < 7; i++) begin
         step();
         check($sformatf("coll.tail%0d.done", i), 32'(done), (i == 6) ? 32'd1 : 32'd0);
         check($sformatf("coll.tail%0d.busy", i), 32'(busy), (i == 6) ? 32'd0 : 32'd1);
      end
      check("coll.rx_data", 32'(rx_data), 32'h80);
      idle_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Parametrised SPI serialiser/deserialiser. It is the successor to the fixed 8-bit LSB-first shift register.
- Adds per-frame bit order, variable frame length, a bit counter and separate sample/shift strobes, so one engine supports all four CPOL/CPHA modes.
- Adds completion pulses, a held receive word, back-to-back frame loading and collision detection.
- Sits between the CPU-side register/FIFO interface and the SPI pin logic. The master and slave wrappers drive its strobes.

Parameters:
- DATA_LEN, 8, maximum frame width in bits; must be ≥ 2.
- CNT_W, $clog2(DATA_LEN+1), width of frame_len and the bit counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  DATA_LEN  parallel transmit word from the CPU.
- load  input  1  request to start a frame with data_in, lsb_first and frame_len.
- lsb_first  input  1  bit order for the frame: 1 = LSB first, 0 = MSB first. Sampled on an accepted load.
- frame_len  input  CNT_W  frame length in bits. 0 or any value > DATA_LEN means DATA_LEN. Sampled on an accepted load.
- sample_en  input  1  strobe: capture serial_in into the sample latch.
- shift_en  input  1  strobe: advance the shift register by one bit.
- serial_in  input  1  serial input (MISO in master use, MOSI in slave use).
- serial_out  output  1  serial output, current transmit bit.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse: frame completed.
- rx_data  output  DATA_LEN  last received word, right-aligned, upper bits zero.
- collision  output  1  one-cycle pulse: load rejected because a frame is in progress.

Behaviour:
- Reset (synchronous, overrides everything, including mid-frame):
  - sr = 0, bit counter = 0, sample latch = 0.
  - Mode = MSB first, len = DATA_LEN.
  - busy = 0, done = 0, collision = 0, rx_data = 0, serial_out = 0.
- Load acceptance:
  - A load is accepted when busy = 0, or when busy = 1 and the last shift_en of the frame occurs in the same cycle (seamless back-to-back).
  - Accepted load:
    - len = effective frame_len.
    - mode = lsb_first.
    - sr[len-1:0] = data_in[len-1:0] and sr bits ≥ len = 0.
    - counter = len, busy = 1 at the next edge.
  - A load that is not accepted leaves state unchanged and pulses collision for 1 cycle.
- serial_out (combinational from registered state):
  - busy = 1, MSB first: sr[len-1].
  - busy = 1, LSB first: sr[0].
  - busy = 0: 0.
  - The first bit is valid the cycle after load, before any strobe. This serves CPHA = 0.
- sample_en while busy: latch <= serial_in. Ignored while idle.
- shift_en while busy:
  - Inserted bit b = serial_in if sample_en is high in the same cycle, else latch.
  - MSB first: sr[len-1:0] <= {sr[len-2:0], b}.
  - LSB first: sr[len-1:0] <= {b, sr[len-1:1]}.
  - Bits ≥ len stay 0.
  - counter decrements.
- shift_en while idle: ignored.
- Completion (the shift_en that moves counter 1→0):
  - At that edge, rx_data <= post-shift sr with bits ≥ len zeroed, busy <= 0, done <= 1 for exactly one cycle.
  - If a load is accepted in the same cycle: busy stays 1, the new frame is loaded, done still pulses, and rx_data captures the completed frame.
- Received bits are right-aligned in both orders:
  - MSB first: the first received bit lands at rx_data[len-1].
  - LSB first: the first received bit lands at rx_data[0].
- rx_data holds until the next completion or reset.
- load and a non-final shift_en in the same cycle while busy: the shift proceeds and collision pulses.
- Strobes are level-qualified per clk cycle. A strobe held high for N cycles is N events.

Test Plan:
- Loopback MSB first, serial_out tied to serial_in, frame_len = 0:
  - load 0xA5, then 8 × (sample_en, next cycle shift_en) → serial_out sequence 1,0,1,0,0,1,0,1.
  - done pulses once, rx_data = 0xA5, busy low after the 8th shift.
- LSB first, frame_len = 8, data_in = 0x3C, serial_in driven 1,1,0,0,0,0,0,1 with simultaneous sample_en/shift_en → serial_out 0,0,1,1,1,1,0,0 and rx_data = 0x83.
- Short frame, frame_len = 5, MSB first:
  - load 0xFF → exactly 5 bits of 1 are output, done after the 5th shift.
  - serial_in = 1,0,1,1,0 → rx_data = 0x16.
- Back-to-back and collision:
  - load 0x81 plus frame_len = 3, assert load with 0x42 during the final shift_en → busy never drops, done pulses, the second frame starts.
  - load mid-frame on a non-final cycle → collision pulses 1 cycle and the frame is undisturbed.
- Reset mid-frame after 3 shifts:
  - rst 1 cycle → busy = 0, serial_out = 0, rx_data = 0, no done pulse.
  - Further shift_en is ignored until the next load.
- frame_len = 12 with DATA_LEN = 8 → treated as 8.
- Idle sample_en/shift_en pulses → no state change, no done.
